uart_mmio_controller: RTL and testbench

Memory-mapped controller between the core data bus and the Uart transceiver. It buffers transmit bytes in a TX FIFO and sequences them into the Uart one at a time using the write_enable/busy handshake. It captures received bytes into an RX FIFO and exposes the DATA, STATUS, CLK_FREQ and BAUD registers. It replaces the ad-hoc combinational UART decode in the top level; the top muxes read_data on hit.

---
 rtl/uart_mmio_controller_if.sv | 25 ++
 rtl/uart_mmio_controller.sv | 193 +++++++++++++++++++
 tb/tb_uart_mmio_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_controller_if
// Brief    : Core data-bus port of the UART MMIO controller (core = master).
// Revision : 1.0
// ============================================================================
interface uart_mmio_controller_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output address, write_data, write_enable, read_enable,
    input  read_data, hit
  );

  modport slave (
    input  address, write_data, write_enable, read_enable,
    output read_data, hit
  );
endinterface
`default_nettype wire

// File: rtl/uart_mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_controller
// Brief    : Register window with TX/RX FIFOs sequencing bytes into the Uart.
// Revision : 1.0
// ============================================================================
module uart_mmio_controller #(
  parameter logic [31:0] BASE           = 32'h10010000,
  parameter int          TX_DEPTH       = 8,
  parameter int          RX_DEPTH       = 8,
  parameter logic [31:0] CLK_FREQ_RESET = 32'h0000ffc0,
  parameter logic [31:0] BAUD_RESET     = 32'd11520,
  parameter int          ACK_TIMEOUT    = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  uart_mmio_controller_if.slave bus,
  output logic [7:0]            uart_data,
  output logic                  uart_write_enable,
  input  wire logic             uart_busy,
  input  wire logic [7:0]       uart_rx_data,
  input  wire logic             uart_out_valid,
  output logic [31:0]           clk_frequency,
  output logic [31:0]           baud_rate
);

  localparam int c_tx_aw  = $clog2(TX_DEPTH);
  localparam int c_rx_aw  = $clog2(RX_DEPTH);
  localparam int c_cnt_w  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_ack_last = c_cnt_w'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  logic w_sel_data, w_sel_status, w_sel_clk, w_sel_baud;
  assign w_sel_data   = (bus.address == BASE);
  assign w_sel_status = (bus.address == BASE + 32'h005);
  assign w_sel_clk    = (bus.address == BASE + 32'h100);
  assign w_sel_baud   = (bus.address == BASE + 32'h104);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_ack_cnt;
  logic [7:0]         r_uart_data;
  logic               r_uart_we;
  logic               r_tx_overflow, r_rx_overrun;
  logic [31:0]        r_clk_freq, r_baud;
  logic               w_status_wr;

  assign w_status_wr = bus.write_enable && w_sel_status;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [c_tx_aw:0] r_tx_wr, r_tx_rd;
  logic             w_tx_empty, w_tx_full, w_tx_push_req, w_tx_push, w_tx_pop;

  assign w_tx_empty    = (r_tx_wr == r_tx_rd);
  assign w_tx_full     = (r_tx_wr[c_tx_aw] != r_tx_rd[c_tx_aw]) &&
                         (r_tx_wr[c_tx_aw-1:0] == r_tx_rd[c_tx_aw-1:0]);
  assign w_tx_push_req = bus.write_enable && w_sel_data;
  assign w_tx_pop      = (r_state == S_IDLE) && !w_tx_empty && !uart_busy;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wr[c_tx_aw-1:0]] <= bus.write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr       <= '0;
      r_tx_rd       <= '0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + (c_tx_aw+1)'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + (c_tx_aw+1)'(1);
      r_tx_overflow <= (w_tx_push_req && w_tx_full && !w_tx_pop) ||
                       (r_tx_overflow && !(w_status_wr && bus.write_data[2]));
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [c_rx_aw:0] r_rx_wr, r_rx_rd;
  logic             w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[c_rx_aw] != r_rx_rd[c_rx_aw]) &&
                      (r_rx_wr[c_rx_aw-1:0] == r_rx_rd[c_rx_aw-1:0]);
  assign w_rx_pop   = bus.read_enable && w_sel_data && !w_rx_empty;
  assign w_rx_push  = uart_out_valid && (!w_rx_full || w_rx_pop);

  always_ff @(posedge clk) begin
    if (w_rx_push)
      r_rx_mem[r_rx_wr[c_rx_aw-1:0]] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wr      <= '0;
      r_rx_rd      <= '0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + (c_rx_aw+1)'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + (c_rx_aw+1)'(1);
      r_rx_overrun <= (uart_out_valid && w_rx_full && !w_rx_pop) ||
                      (r_rx_overrun && !(w_status_wr && bus.write_data[1]));
    end
  end

  // ---------------------------------------------------------------- TX FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack_cnt   <= '0;
      r_uart_data <= 8'h00;
      r_uart_we   <= 1'b0;
    end else begin
      r_uart_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_uart_data <= r_tx_mem[r_tx_rd[c_tx_aw-1:0]];
            r_uart_we   <= 1'b1;
            r_state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_ack_cnt <= '0;
          r_state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // A Uart that never acknowledges must not wedge the queue.
          if (uart_busy)                    r_state   <= S_WAIT_DONE;
          else if (r_ack_cnt == c_ack_last) r_state   <= S_IDLE;
          else                              r_ack_cnt <= r_ack_cnt + c_cnt_w'(1);
        end
        S_WAIT_DONE: begin
          if (!uart_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_data         = r_uart_data;
  assign uart_write_enable = r_uart_we;

  // ---------------------------------------------------------------- config regs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_freq <= CLK_FREQ_RESET;
      r_baud     <= BAUD_RESET;
    end else begin
      if (bus.write_enable && w_sel_clk)  r_clk_freq <= bus.write_data;
      if (bus.write_enable && w_sel_baud) r_baud     <= bus.write_data;
    end
  end

  assign clk_frequency = r_clk_freq;
  assign baud_rate     = r_baud;

  // ---------------------------------------------------------------- read mux
  logic [7:0] w_status;
  assign w_status = {w_tx_full,
                     (!w_tx_empty || (r_state != S_IDLE) || uart_busy),
                     1'b0, w_tx_empty, 1'b0,
                     r_tx_overflow, r_rx_overrun, !w_rx_empty};

  always_comb begin
    bus.read_data = 32'h0;
    bus.hit       = 1'b0;
    if (w_sel_data) begin
      bus.hit = 1'b1;
      if (!w_rx_empty) bus.read_data = {24'h0, r_rx_mem[r_rx_rd[c_rx_aw-1:0]]};
    end else if (w_sel_status) begin
      bus.hit       = 1'b1;
      bus.read_data = {24'h0, w_status};
    end else if (w_sel_clk) begin
      bus.hit       = 1'b1;
      bus.read_data = r_clk_freq;
    end else if (w_sel_baud) begin
      bus.hit       = 1'b1;
      bus.read_data = r_baud;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mmio_controller
// Brief    : Directed bench for uart_mmio_controller with a simple Uart model.
// Revision : 1.0
// ============================================================================
module tb_uart_mmio_controller;

  localparam logic [31:0] c_base = 32'h10010000;

  logic        clk;
  logic        rst;
  logic [7:0]  uart_data;
  logic        uart_write_enable;
  logic        uart_busy;
  logic [7:0]  uart_rx_data;
  logic        uart_out_valid;
  logic [31:0] clk_frequency;
  logic [31:0] baud_rate;

  uart_mmio_controller_if bus_if ();

  uart_mmio_controller dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus_if),
    .uart_data         (uart_data),
    .uart_write_enable (uart_write_enable),
    .uart_busy         (uart_busy),
    .uart_rx_data      (uart_rx_data),
    .uart_out_valid    (uart_out_valid),
    .clk_frequency     (clk_frequency),
    .baud_rate         (baud_rate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Uart model: busy for 3 cycles after each launch, or forced by hold_busy.
  logic       hold_busy;
  logic [1:0] busy_cnt;
  logic       prev_we;
  int         launches;
  int         doubles;
  logic [7:0] log_mem [64];

  assign uart_busy = hold_busy | (busy_cnt != 2'd0);

  initial begin
    busy_cnt = 2'd0;
    prev_we  = 1'b0;
    launches = 0;
    doubles  = 0;
  end

  always @(posedge clk) begin
    if (rst)                    busy_cnt <= 2'd0;
    else if (uart_write_enable) busy_cnt <= 2'd3;
    else if (busy_cnt != 2'd0)  busy_cnt <= busy_cnt - 2'd1;
    if (uart_write_enable) begin
      log_mem[launches[5:0]] <= uart_data;
      launches <= launches + 1;
      if (prev_we) doubles <= doubles + 1;
    end
    prev_we <= uart_write_enable;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    bus_if.address      = c_base + off;
    bus_if.write_data   = data;
    bus_if.write_enable = 1'b1;
    tick();
    bus_if.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] val);
    bus_if.address     = c_base + off;
    bus_if.read_enable = 1'b0;
    #1;
    val = bus_if.read_data;
  endtask

  task automatic rd_pop(output logic [31:0] val);
    bus_if.address     = c_base;
    bus_if.read_enable = 1'b1;
    #1;
    val = bus_if.read_data;
    tick();
    bus_if.read_enable = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    uart_rx_data   = d;
    uart_out_valid = 1'b1;
    tick();
    uart_out_valid = 1'b0;
  endtask

  // Waits for the launch count to reach n with the controller fully idle.
  task automatic wait_idle(input int n, output logic ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rd(32'h5, s);
      if (launches == n && s == 32'h10) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        ok;
    int          base;

    rst                 = 1'b1;
    hold_busy           = 1'b0;
    uart_rx_data        = 8'h00;
    uart_out_valid      = 1'b0;
    bus_if.address      = 32'h0;
    bus_if.write_data   = 32'h0;
    bus_if.write_enable = 1'b0;
    bus_if.read_enable  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: reset state
    rd(32'h5, v);   chk("rst_status", v, 32'h10);
    chk("rst_status_hit", {31'h0, bus_if.hit}, 32'h1);
    rd(32'h100, v); chk("rst_clk_freq", v, 32'h0000ffc0);
    rd(32'h104, v); chk("rst_baud", v, 32'd11520);
    chk("rst_uart_we", {31'h0, uart_write_enable}, 32'h0);
    chk("rst_clk_out", clk_frequency, 32'h0000ffc0);
    rd(32'h4, v);   chk("miss_read_data", v, 32'h0);
    chk("miss_hit", {31'h0, bus_if.hit}, 32'h0);

    // 2: three bytes through the launch handshake
    base = launches;
    wr(32'h0, 32'h41);
    chk("lat_we_cycle1", {31'h0, uart_write_enable}, 32'h0);
    tick();
    chk("lat_we_cycle2", {31'h0, uart_write_enable}, 32'h1);
    chk("lat_data", {24'h0, uart_data}, 32'h41);
    wr(32'h0, 32'h42);
    wr(32'h0, 32'h43);
    wait_idle(base + 3, ok);
    chk("t2_idle", {31'h0, ok}, 32'h1);
    chk("t2_launches", launches - base, 32'd3);
    chk("t2_byte0", {24'h0, log_mem[base]}, 32'h41);
    chk("t2_byte1", {24'h0, log_mem[base+1]}, 32'h42);
    chk("t2_byte2", {24'h0, log_mem[base+2]}, 32'h43);
    chk("t2_single_cycle", doubles, 32'd0);
    rd(32'h5, v); chk("t2_status", v, 32'h10);

    // 3: overflow while the Uart is held busy
    hold_busy = 1'b1;
    base = launches;
    for (int i = 0; i < 9; i++) wr(32'h0, 32'h60 + i);
    rd(32'h5, v); chk("t3_full_ovf", v, 32'hC4);
    wr(32'h5, 32'h04);
    rd(32'h5, v); chk("t3_w1c", v, 32'hC0);
    hold_busy = 1'b0;
    wait_idle(base + 8, ok);
    chk("t3_idle", {31'h0, ok}, 32'h1);
    for (int i = 0; i < 8; i++) chk("t3_byte", {24'h0, log_mem[base+i]}, 32'h60 + i);
    repeat (20) tick();
    chk("t3_launches", launches - base, 32'd8);

    // 4: RX capture and pops
    rx_push(8'h5A);
    rd(32'h5, v); chk("t4_rx_valid", v, 32'h11);
    rd(32'h0, v); chk("t4_peek", v, 32'h5A);
    rx_push(8'hA5);
    rd_pop(v); chk("t4_pop0", v, 32'h5A);
    rd_pop(v); chk("t4_pop1", v, 32'hA5);
    rd_pop(v); chk("t4_pop_empty", v, 32'h0);
    rd(32'h5, v); chk("t4_status", v, 32'h10);

    // 5: RX overrun, then simultaneous pop and push while full
    for (int i = 0; i < 9; i++) rx_push(8'h80 + 8'(i));
    rd(32'h5, v); chk("t5_overrun", v, 32'h13);
    bus_if.address     = c_base;
    bus_if.read_enable = 1'b1;
    uart_rx_data       = 8'h99;
    uart_out_valid     = 1'b1;
    #1;
    chk("t5_head", bus_if.read_data, 32'h80);
    tick();
    bus_if.read_enable = 1'b0;
    uart_out_valid     = 1'b0;
    for (int i = 1; i < 8; i++) begin
      rd_pop(v); chk("t5_keep", v, 32'h80 + i);
    end
    rd_pop(v); chk("t5_last", v, 32'h99);
    rd(32'h5, v); chk("t5_drained", v, 32'h12);
    wr(32'h5, 32'h02);
    rd(32'h5, v); chk("t5_w1c", v, 32'h10);

    // 6: reset during WAIT_DONE with three bytes queued
    base = launches;
    for (int i = 0; i < 4; i++) wr(32'h0, 32'hB0 + i);
    for (int i = 0; i < 20 && launches == base; i++) tick();
    chk("t6_first_launch", launches - base, 32'd1);
    hold_busy = 1'b1;
    repeat (3) tick();
    rd(32'h5, v); chk("t6_pre_rst", v, 32'h40);
    rst = 1'b1;
    hold_busy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    rd(32'h5, v); chk("t6_post_rst", v, 32'h10);
    chk("t6_uart_data", {24'h0, uart_data}, 32'h0);
    repeat (30) tick();
    chk("t6_no_launch", launches - base, 32'd1);
    wr(32'h100, 32'h1000);
    chk("t6_clk_freq", clk_frequency, 32'h1000);
    rd(32'h100, v); chk("t6_clk_read", v, 32'h1000);
    wr(32'h104, 32'd9600);
    chk("t6_baud", baud_rate, 32'd9600);
    rd(32'h108, v); chk("t6_miss", {31'h0, bus_if.hit}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
